// File: rtl/kernel_load_ctrl.sv
// kernel_load_ctrl
//   Copies a block of kernel weights from the weight memory into the
//   kernel register file, one word at a time: request, wait for read
//   data, then write the word to the matching kernel register.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_start                  start pulse, only honoured in IDLE
//   i_abort                  synchronous abort back to IDLE
//   i_base_addr              first memory address (latched at start)
//   i_num_words              words to load, clamped to KREG_DEPTH (latched)
//   o_mem_req/o_mem_addr     memory read request and address
//   i_mem_gnt                request accepted
//   i_mem_rvalid/i_mem_rdata read data return
//   o_kreg_wr_*              kernel register file write port
//   o_busy, o_done, o_state  status and FSM state for monitoring
module kernel_load_ctrl #(
    parameter int DATA_W     = 8,
    parameter int KREG_DEPTH = 64,
    parameter int KREG_AW    = 6,
    parameter int MEM_AW     = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [MEM_AW-1:0]   i_base_addr,
    input  logic [KREG_AW:0]    i_num_words,
    output logic                o_mem_req,
    output logic [MEM_AW-1:0]   o_mem_addr,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_kreg_wr_en,
    output logic [KREG_AW-1:0]  o_kreg_wr_addr,
    output logic [DATA_W-1:0]   o_kreg_wr_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [KREG_AW:0] DEPTH_W = (KREG_AW+1)'(KREG_DEPTH);

    state_t              state;
    state_t              state_next;
    logic [MEM_AW-1:0]   base;
    logic [KREG_AW:0]    count;
    logic [KREG_AW:0]    num_clamped;
    logic [KREG_AW-1:0]  idx;
    logic [DATA_W-1:0]   data;
    logic                load;
    logic                capture;
    logic                advance;
    logic                last_word;

    assign num_clamped = (i_num_words > DEPTH_W) ? DEPTH_W : i_num_words;

    // count is at least 1 whenever WRITE is reached, so count-1 cannot underflow there
    assign last_word = ({1'b0, idx} == (count - (KREG_AW+1)'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            base  <= '0;
            count <= '0;
            idx   <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                base  <= i_base_addr;
                count <= num_clamped;
                idx   <= '0;
            end
            if (capture) begin
                data <= i_mem_rdata;
            end
            if (advance) begin
                idx <= idx + KREG_AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    load       = 1'b1;
                    state_next = (num_clamped == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_next = S_DONE;
                end else begin
                    advance    = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides every other transition outside IDLE
        if (i_abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
            capture    = 1'b0;
            advance    = 1'b0;
        end
    end

    always_comb begin
        o_mem_req      = (state == S_REQ);
        o_mem_addr     = o_mem_req ? (base + MEM_AW'(idx)) : '0;
        o_kreg_wr_en   = (state == S_WRITE) && !i_abort;
        o_kreg_wr_addr = o_kreg_wr_en ? idx : '0;
        o_kreg_wr_data = o_kreg_wr_en ? data : '0;
        o_busy         = (state != S_IDLE);
        o_done         = (state == S_DONE);
        o_state        = state;
    end

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// tb_kernel_load_ctrl
//   Self-checking bench for kernel_load_ctrl: a directed vector table,
//   randomized loads checked against a transaction-level model (expected
//   address/data streams and completion time derived from base, count
//   and per-word stall lengths), plus reset sequences.
module tb_kernel_load_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] base_addr;
    logic [6:0] num_words;
    logic       mem_req;
    logic [9:0] mem_addr;
    logic       gnt;
    logic       rvalid;
    logic [7:0] rdata;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic [2:0] state;

    int passed;
    int total;

    logic [7:0] mem [1024];
    int gd [64];
    int rd [64];

    kernel_load_ctrl #(
        .DATA_W     (8),
        .KREG_DEPTH (64),
        .KREG_AW    (6),
        .MEM_AW     (10)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_base_addr    (base_addr),
        .i_num_words    (num_words),
        .o_mem_req      (mem_req),
        .o_mem_addr     (mem_addr),
        .i_mem_gnt      (gnt),
        .i_mem_rvalid   (rvalid),
        .i_mem_rdata    (rdata),
        .o_kreg_wr_en   (wr_en),
        .o_kreg_wr_addr (wr_addr),
        .o_kreg_wr_data (wr_data),
        .o_busy         (busy),
        .o_done         (done),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0] base;
        int         num;
        int         stall_word;
        int         gdel;
        int         rdel;
        int         abort_word;
        int         exp_writes;
        int         exp_done;
    } vec_t;

    vec_t tbl [10];

    // One load: drive start, act as memory (grant/return data after the
    // stall lengths in gd/rd), watch the write port against the expected stream.
    task automatic run_load(input logic [9:0] b, input int n, input int aw,
                            input int exp_wr, input int exp_done, input string tag);
        int         cyc;
        int         nwr;
        int         nrd;
        int         ndone;
        int         done_cyc;
        int         gcnt;
        int         rcnt;
        int         post;
        int         bad;
        int         exp_rd;
        bit         rpend;
        bit         aborted;
        bit         done_seen;
        bit         finished;
        logic [9:0] raddr;
        logic [9:0] ea;

        cyc = 0; nwr = 0; nrd = 0; ndone = 0; done_cyc = -1;
        gcnt = 0; rcnt = 0; post = 0; bad = 0;
        rpend = 0; aborted = 0; done_seen = 0; finished = 0;
        raddr = '0;
        exp_rd = (aw >= 0) ? aw + 1 : exp_wr;

        @(negedge clk);
        start = 1'b1; base_addr = b; num_words = 7'(n);
        abort = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        start = 1'b0;

        while (!finished && cyc < 1000) begin
            gnt = 1'b0; rvalid = 1'b0; abort = 1'b0;
            rdata = 8'($urandom);
            // operand inputs change freely; only the start-time values count
            base_addr = 10'($urandom);
            num_words = 7'($urandom);
            start = busy && ($urandom_range(0, 7) == 0);

            if (done_seen) begin
                chk({tag, " idle_after_done"}, {busy, state}, 0);
                finished = 1;
            end else if (aborted) begin
                post++;
                if (post == 1) chk({tag, " idle_after_abort"}, {busy, state}, 0);
                if (post >= 6) finished = 1;
            end else if (!busy) begin
                bad++;
            end

            if (mem_req) begin
                ea = b + 10'(nrd);
                chk({tag, " mem_addr"}, mem_addr, ea);
                if (nrd < 64 && gcnt >= gd[nrd]) begin
                    gnt = 1'b1; gcnt = 0; rpend = 1; rcnt = 0; raddr = ea; nrd++;
                end else begin
                    gcnt++;
                end
                rvalid = 1'($urandom_range(0, 1));
            end else if (rpend) begin
                if (rcnt >= rd[nrd-1]) begin
                    rvalid = 1'b1; rdata = mem[raddr]; rpend = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rvalid = ($urandom_range(0, 3) == 0);
            end
            if (!mem_req && mem_addr != '0) bad++;

            if (wr_en) begin
                if (!aborted && nwr == aw) begin
                    abort = 1'b1;
                    #1;
                    chk({tag, " wr_en_gated_by_abort"}, wr_en, 0);
                    aborted = 1;
                end else begin
                    ea = b + 10'(nwr);
                    chk({tag, " wr_addr"}, wr_addr, nwr);
                    chk({tag, " wr_data"}, wr_data, mem[ea]);
                    nwr++;
                end
            end else if (wr_addr != '0 || wr_data != '0) begin
                bad++;
            end

            if (done) begin
                ndone++; done_cyc = cyc; done_seen = 1;
            end

            @(negedge clk);
            cyc++;
        end

        start = 1'b0; gnt = 1'b0; rvalid = 1'b0; abort = 1'b0;
        chk({tag, " terminated"}, finished, 1);
        chk({tag, " write_count"}, nwr, exp_wr);
        chk({tag, " read_count"}, nrd, exp_rd);
        chk({tag, " done_pulses"}, ndone, (exp_done >= 0) ? 1 : 0);
        if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " idle_zero_and_busy"}, bad, 0);
    endtask

    task automatic async_reset_test();
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 10'h100; num_words = 7'd4;
        @(negedge clk);
        start = 1'b0;
        chk("areset pre_state_req", state, 1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("areset pre_state_wait", state, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset outputs_zero",
            {mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done}, 0);
        chk("areset state_zero", state, 0);
        rvalid = 1'b1; rdata = 8'h5A;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_en || busy || state != 3'd0) bad++;
        end
        rvalid = 1'b0;
        chk("areset stray_rvalid_ignored", bad, 0);
    endtask

    initial begin
        passed = 0; total = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        base_addr = '0; num_words = '0; rdata = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);

        tbl[0] = '{10'h010,   4, -1, 0, 0, -1,  4,  12};
        tbl[1] = '{10'h3F0,  64, -1, 0, 0, -1, 64, 192};
        tbl[2] = '{10'h123,   0, -1, 0, 0, -1,  0,   0};
        tbl[3] = '{10'h200, 100, -1, 0, 0, -1, 64, 192};
        tbl[4] = '{10'h050,   4,  1, 3, 5, -1,  4,  20};
        tbl[5] = '{10'h080,   8, -1, 0, 0,  2,  2,  -1};
        tbl[6] = '{10'h090,   8, -1, 0, 0, -1,  8,  24};
        tbl[7] = '{10'h3FF,   1, -1, 0, 0, -1,  1,   3};
        tbl[8] = '{10'h000,  64, -1, 0, 0, 63, 63,  -1};
        tbl[9] = '{10'h155, 127, -1, 0, 0, -1, 64, 192};

        #12;
        chk("reset outputs_zero",
            {mem_req, mem_addr, wr_en, wr_addr, wr_data, busy, done}, 0);
        chk("reset state_zero", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset idle_after_release", {busy, state}, 0);

        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 64; k++) begin gd[k] = 0; rd[k] = 0; end
            if (tbl[t].stall_word >= 0) begin
                gd[tbl[t].stall_word] = tbl[t].gdel;
                rd[tbl[t].stall_word] = tbl[t].rdel;
            end
            run_load(tbl[t].base, tbl[t].num, tbl[t].abort_word,
                     tbl[t].exp_writes, tbl[t].exp_done, $sformatf("vec%0d", t));
        end

        async_reset_test();
        for (int k = 0; k < 64; k++) begin gd[k] = 0; rd[k] = 0; end
        run_load(10'h100, 4, -1, 4, 12, "after_areset");

        for (int r = 0; r < 25; r++) begin
            logic [9:0] b;
            int n;
            int neff;
            int aw;
            int sum;
            int dn;
            b = 10'($urandom);
            n = $urandom_range(0, 80);
            neff = (n > 64) ? 64 : n;
            aw = -1;
            sum = 0;
            for (int k = 0; k < 64; k++) begin
                gd[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                rd[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            if (neff > 0 && $urandom_range(0, 3) == 0) aw = $urandom_range(0, neff - 1);
            for (int k = 0; k < neff; k++) sum += gd[k] + rd[k];
            dn = (aw >= 0) ? -1 : 3 * neff + sum;
            run_load(b, n, aw, (aw >= 0) ? aw : neff, dn, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
